ssd_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for the digital clock's seven-segment display. It owns the single shared BCD-to-seven-segment decoder and serves one display digit per time slot, driving active-low common anodes and segments. It sits between the timekeeping counters, which supply packed BCD digits, and the board pins. Each slot has a leading blanking interval so the decoder output settles before an anode turns on, which prevents ghosting.

---
 rtl/ssd_scan_ctrl_if.sv | 25 ++
 rtl/ssd_scan_ctrl.sv | 124 ++++++++++++
 tb/tb_ssd_scan_ctrl.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ssd_scan_ctrl_if.sv
// Signal bundle between the display scan controller, the timekeeping counters,
// the shared BCD-to-segment decoder and the board pins.
interface ssd_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    logic                      en;
    logic [4*NUM_DIGITS-1:0]   digits;
    logic [NUM_DIGITS-1:0]     dp;
    logic [NUM_DIGITS-1:0]     blank;
    logic [3:0]                bcd;
    logic [7:0]                ssd_raw;
    logic [7:0]                seg;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_start;

    modport master (
        output en, digits, dp, blank, ssd_raw,
        input  bcd, seg, an, frame_start
    );

    modport slave (
        input  en, digits, dp, blank, ssd_raw,
        output bcd, seg, an, frame_start
    );
endinterface

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed seven-segment scan controller: one digit per slot, with a
// leading blanking interval so the shared decoder settles before the anode turns on.
//
// state | meaning
// IDLE  | display dark, waiting for en
// SCAN  | cycling through digit slots
module ssd_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    ssd_scan_ctrl_if.slave  bus
);
    localparam int CNT_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t                          state_q, state_d;
    logic [CNT_W-1:0]                cnt_q, cnt_d;
    logic [IDX_W-1:0]                idx_q, idx_d, idx_next;
    logic [3:0]                      bcd_q, bcd_d;
    logic [7:0]                      seg_q, seg_d;
    logic [NUM_DIGITS-1:0]           an_q, an_d;
    logic                            frame_start_q, frame_start_d;
    logic [NUM_DIGITS-1:0][3:0]      snap_digit_q, snap_digit_d;
    logic [NUM_DIGITS-1:0]           snap_dp_q, snap_dp_d;
    logic [NUM_DIGITS-1:0]           snap_blank_q, snap_blank_d;
    logic                            start_frame;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        idx_d         = idx_q;
        bcd_d         = bcd_q;
        seg_d         = seg_q;
        an_d          = '1;
        frame_start_d = 1'b0;
        snap_digit_d  = snap_digit_q;
        snap_dp_d     = snap_dp_q;
        snap_blank_d  = snap_blank_q;
        start_frame   = 1'b0;
        idx_next      = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;

        case (state_q)
            IDLE: begin
                seg_d = 8'hFF;
                cnt_d = '0;
                idx_d = '0;
                if (bus.en) begin
                    state_d     = SCAN;
                    start_frame = 1'b1;
                end
            end
            SCAN: begin
                if (!bus.en) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    idx_d   = '0;
                    seg_d   = 8'hFF;
                end else begin
                    // ssd_raw reflects bcd_q, which belongs to the current idx
                    seg_d = {~snap_dp_q[idx_q], bus.ssd_raw[6:0]};
                    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
                        cnt_d = '0;
                        idx_d = idx_next;
                        if (idx_next == '0) start_frame = 1'b1;
                        else                bcd_d = snap_digit_q[idx_next];
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Slot 0 takes the live digit since the snapshot is loading on the same edge
        if (start_frame) begin
            cnt_d         = '0;
            idx_d         = '0;
            snap_digit_d  = bus.digits;
            snap_dp_d     = bus.dp;
            snap_blank_d  = bus.blank;
            bcd_d         = bus.digits[3:0];
            frame_start_d = 1'b1;
        end

        if (state_d == SCAN && cnt_d >= CNT_W'(BLANK_CYCLES) && !snap_blank_d[idx_d])
            an_d[idx_d] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            idx_q         <= '0;
            bcd_q         <= 4'h0;
            seg_q         <= 8'hFF;
            an_q          <= '1;
            frame_start_q <= 1'b0;
            snap_digit_q  <= '0;
            snap_dp_q     <= '0;
            snap_blank_q  <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            bcd_q         <= bcd_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
            snap_digit_q  <= snap_digit_d;
            snap_dp_q     <= snap_dp_d;
            snap_blank_q  <= snap_blank_d;
        end
    end

    assign bus.bcd         = bcd_q;
    assign bus.seg         = seg_q;
    assign bus.an          = an_q;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Directed bench for ssd_scan_ctrl with a behavioural decoder on bcd/ssd_raw.
module tb_ssd_scan_ctrl;
    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;

    ssd_scan_ctrl_if #(.NUM_DIGITS(4)) bus ();

    ssd_scan_ctrl #(
        .NUM_DIGITS  (4),
        .REFRESH_DIV (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Shared decoder: active-low {dp, g, f, e, d, c, b, a}
    always_comb begin
        case (bus.bcd)
            4'd0:    bus.ssd_raw = 8'hC0;
            4'd1:    bus.ssd_raw = 8'hF9;
            4'd2:    bus.ssd_raw = 8'hA4;
            4'd3:    bus.ssd_raw = 8'hB0;
            4'd4:    bus.ssd_raw = 8'h99;
            4'd5:    bus.ssd_raw = 8'h92;
            4'd6:    bus.ssd_raw = 8'h82;
            4'd7:    bus.ssd_raw = 8'hF8;
            4'd8:    bus.ssd_raw = 8'h80;
            4'd9:    bus.ssd_raw = 8'h90;
            default: bus.ssd_raw = 8'hBF;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Checks ncyc cycles of slot s, sampling on the falling edge
    task automatic run_slot(input int s, input logic [3:0] e_bcd, input logic [7:0] e_seg,
                            input logic e_blank, input int ncyc);
        logic [3:0] an_on;
        logic [3:0] an_exp;
        an_on = ~(4'(1) << s);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            an_exp = (c >= 2 && !e_blank) ? an_on : 4'hF;
            chk($sformatf("slot%0d_c%0d_frame_start", s, c), 32'(bus.frame_start),
                32'((s == 0 && c == 0) ? 1 : 0));
            chk($sformatf("slot%0d_c%0d_bcd", s, c), 32'(bus.bcd), 32'(e_bcd));
            chk($sformatf("slot%0d_c%0d_an", s, c), 32'(bus.an), 32'(an_exp));
            if (c >= 1)
                chk($sformatf("slot%0d_c%0d_seg", s, c), 32'(bus.seg), 32'(e_seg));
        end
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        rst_n      = 1'b0;
        bus.en     = 1'b1;
        bus.digits = 16'h1234;
        bus.dp     = 4'b0000;
        bus.blank  = 4'b0000;

        // Reset hold with en high
        repeat (2) @(negedge clk);
        chk("rst_an", 32'(bus.an), 32'hF);
        chk("rst_seg", 32'(bus.seg), 32'hFF);
        chk("rst_bcd", 32'(bus.bcd), 32'h0);
        chk("rst_frame_start", 32'(bus.frame_start), 32'h0);
        rst_n = 1'b1;

        // Frame 1: 1234; dp/blank requests arrive mid-frame and must wait
        run_slot(0, 4'd4, 8'h99, 1'b0, 8);
        run_slot(1, 4'd3, 8'hB0, 1'b0, 8);
        bus.dp    = 4'b0100;
        bus.blank = 4'b1000;
        run_slot(2, 4'd2, 8'hA4, 1'b0, 8);
        run_slot(3, 4'd1, 8'hF9, 1'b0, 8);

        // Frame 2: dp on digit 2, digit 3 blanked; new digits arrive during slot 1
        run_slot(0, 4'd4, 8'h99, 1'b0, 8);
        run_slot(1, 4'd3, 8'hB0, 1'b0, 8);
        bus.digits = 16'h5678;
        bus.dp     = 4'b0000;
        bus.blank  = 4'b0000;
        run_slot(2, 4'd2, 8'h24, 1'b0, 8);
        run_slot(3, 4'd1, 8'hF9, 1'b1, 8);

        // Frame 3: 5678
        run_slot(0, 4'd8, 8'h80, 1'b0, 8);
        run_slot(1, 4'd7, 8'hF8, 1'b0, 8);
        run_slot(2, 4'd6, 8'h82, 1'b0, 8);
        run_slot(3, 4'd5, 8'h92, 1'b0, 8);

        // Drop en at cnt=5 of slot 1
        run_slot(0, 4'd8, 8'h80, 1'b0, 8);
        run_slot(1, 4'd7, 8'hF8, 1'b0, 6);
        bus.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("dis%0d_an", i), 32'(bus.an), 32'hF);
            chk($sformatf("dis%0d_seg", i), 32'(bus.seg), 32'hFF);
            chk($sformatf("dis%0d_frame_start", i), 32'(bus.frame_start), 32'h0);
        end
        bus.en = 1'b1;
        run_slot(0, 4'd8, 8'h80, 1'b0, 8);
        run_slot(1, 4'd7, 8'hF8, 1'b0, 8);

        // Asynchronous reset while the slot-2 anode is lit
        run_slot(2, 4'd6, 8'h82, 1'b0, 4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_an", 32'(bus.an), 32'hF);
        chk("arst_seg", 32'(bus.seg), 32'hFF);
        chk("arst_bcd", 32'(bus.bcd), 32'h0);
        chk("arst_frame_start", 32'(bus.frame_start), 32'h0);
        bus.digits = 16'h0921;
        @(negedge clk);
        chk("arst_hold_an", 32'(bus.an), 32'hF);
        rst_n = 1'b1;
        run_slot(0, 4'd1, 8'hF9, 1'b0, 8);
        run_slot(1, 4'd2, 8'hA4, 1'b0, 8);
        run_slot(2, 4'd9, 8'h90, 1'b0, 8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
